// File: rtl/mton_sync_fifo_pkg.sv
// Shared helpers for the multi-writer / multi-reader FIFO: capacity math and
// lane-rank popcounts used to compact gapped request vectors.
package mton_fifo_pkg;

  localparam int MAX_LANES = 64;

  typedef logic [MAX_LANES-1:0] lane_vec_t;

  function automatic int cap_of(input int depth);
    return 1 << depth;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Number of set bits strictly below idx; this is a lane's rank among requesters.
  function automatic int popcount_prefix(input lane_vec_t vec, input int idx);
    int n;
    n = 0;
    for (int k = 0; k < MAX_LANES; k++) begin
      if (k < idx && vec[k]) n++;
    end
    return n;
  endfunction

  function automatic int popcount(input lane_vec_t vec);
    return popcount_prefix(vec, MAX_LANES);
  endfunction

endpackage

// File: rtl/mton_sync_fifo_if.sv
// Write/read lane bundle of the M-to-N FIFO; the FIFO is the slave side.
interface mton_sync_fifo_if #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int M_WRITERS = 2,
  parameter int N_READERS = 2
);

  logic [M_WRITERS-1:0]       i_wr_en;
  logic [M_WRITERS*WIDTH-1:0] i_wr_data;
  logic [M_WRITERS-1:0]       o_wr_ed;
  logic                       o_wr_full;
  logic                       o_wr_afull;
  logic                       o_wr_pfull;
  logic [DEPTH:0]             o_wr_remain;

  logic [N_READERS-1:0]       i_rd_en;
  logic [N_READERS-1:0]       o_rd_ed;
  logic [N_READERS*WIDTH-1:0] o_rd_data;
  logic                       o_rd_empty;
  logic                       o_rd_aempty;
  logic                       o_rd_pempty;
  logic [DEPTH:0]             o_rd_depth;

  logic                       o_err_ovf;
  logic                       o_err_udf;

  modport master (
    output i_wr_en, i_wr_data, i_rd_en,
    input  o_wr_ed, o_wr_full, o_wr_afull, o_wr_pfull, o_wr_remain,
    input  o_rd_ed, o_rd_data, o_rd_empty, o_rd_aempty, o_rd_pempty, o_rd_depth,
    input  o_err_ovf, o_err_udf
  );

  modport slave (
    input  i_wr_en, i_wr_data, i_rd_en,
    output o_wr_ed, o_wr_full, o_wr_afull, o_wr_pfull, o_wr_remain,
    output o_rd_ed, o_rd_data, o_rd_empty, o_rd_aempty, o_rd_pempty, o_rd_depth,
    output o_err_ovf, o_err_udf
  );

endinterface

// File: rtl/mton_sync_fifo_mem.sv
// CAP x WIDTH register array with M write ports and N asynchronous read ports.
// Write addresses are distinct by construction, so port order does not matter.
module mton_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int NW    = 2,
  parameter int NR    = 2
) (
  input  logic                  i_clk,
  input  logic [NW-1:0]         i_wr_en,
  input  logic [NW*DEPTH-1:0]   i_wr_addr,
  input  logic [NW*WIDTH-1:0]   i_wr_data,
  input  logic [NR*DEPTH-1:0]   i_rd_addr,
  output logic [NR*WIDTH-1:0]   o_rd_data
);

  localparam int CAP = 1 << DEPTH;

  logic [WIDTH-1:0] mem_q [CAP];
  logic [WIDTH-1:0] mem_d [CAP];

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NW; i++) begin
      if (i_wr_en[i]) mem_d[i_wr_addr[i*DEPTH +: DEPTH]] = i_wr_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    o_rd_data = '0;
    for (int j = 0; j < NR; j++) begin
      o_rd_data[j*WIDTH +: WIDTH] = mem_q[i_rd_addr[j*DEPTH +: DEPTH]];
    end
  end

endmodule

// File: rtl/mton_sync_fifo.sv
// Single-clock FIFO accepting up to M words and delivering up to N words per cycle,
// lanes compacted by rank so storage order follows ascending lane index.
module mton_sync_fifo
  import mton_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int M_WRITERS = 2,
  parameter int N_READERS = 2,
  parameter int PFULL_TH  = 12,
  parameter int PEMPTY_TH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  mton_sync_fifo_if.slave fifo
);

  localparam int CAP  = cap_of(DEPTH);
  localparam int CW   = $clog2(max_of(M_WRITERS, N_READERS) + 1);
  localparam int CNTW = DEPTH + 1;

  if (M_WRITERS < 1 || M_WRITERS > CAP || M_WRITERS > MAX_LANES) begin : g_bad_m
    $error("mton_sync_fifo: M_WRITERS out of range");
  end
  if (N_READERS < 1 || N_READERS > CAP || N_READERS > MAX_LANES) begin : g_bad_n
    $error("mton_sync_fifo: N_READERS out of range");
  end
  if (PFULL_TH < 0 || PFULL_TH > CAP || PEMPTY_TH < 0 || PEMPTY_TH > CAP) begin : g_bad_th
    $error("mton_sync_fifo: threshold out of range");
  end

  logic [DEPTH-1:0] wptr_q, wptr_d;
  logic [DEPTH-1:0] rptr_q, rptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic [CNTW-1:0]            free_cnt;
  lane_vec_t                  wr_vec, rd_vec, wed_vec, red_vec;
  logic [CW-1:0]              rank;
  logic [CW-1:0]              nwr, nrd;
  logic [M_WRITERS-1:0]       wr_ed;
  logic [N_READERS-1:0]       rd_ed;
  logic [M_WRITERS*DEPTH-1:0] wr_addr;
  logic [N_READERS*DEPTH-1:0] rd_addr;
  logic [N_READERS*WIDTH-1:0] mem_rd;
  logic [N_READERS*WIDTH-1:0] rd_data;

  // Grants use count sampled at cycle start: a same-cycle pop frees no write space
  // and a same-cycle push is not yet poppable.
  always_comb begin
    free_cnt = CNTW'(CAP) - count_q;
    wr_vec = '0;
    wr_vec[M_WRITERS-1:0] = fifo.i_wr_en;
    rd_vec = '0;
    rd_vec[N_READERS-1:0] = fifo.i_rd_en;
    rank    = '0;
    wr_ed   = '0;
    rd_ed   = '0;
    wr_addr = '0;
    rd_addr = '0;
    for (int i = 0; i < M_WRITERS; i++) begin
      rank     = CW'(popcount_prefix(wr_vec, i));
      wr_ed[i] = !i_rst && fifo.i_wr_en[i] && (CNTW'(rank) < free_cnt);
      wr_addr[i*DEPTH +: DEPTH] = wptr_q + DEPTH'(rank);
    end
    for (int j = 0; j < N_READERS; j++) begin
      rank     = CW'(popcount_prefix(rd_vec, j));
      rd_ed[j] = !i_rst && fifo.i_rd_en[j] && (CNTW'(rank) < count_q);
      rd_addr[j*DEPTH +: DEPTH] = rptr_q + DEPTH'(rank);
    end
    wed_vec = '0;
    wed_vec[M_WRITERS-1:0] = wr_ed;
    red_vec = '0;
    red_vec[N_READERS-1:0] = rd_ed;
    nwr = CW'(popcount(wed_vec));
    nrd = CW'(popcount(red_vec));
  end

  always_comb begin
    wptr_d  = wptr_q + DEPTH'(nwr);
    rptr_d  = rptr_q + DEPTH'(nrd);
    count_d = count_q + CNTW'(nwr) - CNTW'(nrd);
    ovf_d   = ovf_q | (|(fifo.i_wr_en & ~wr_ed));
    udf_d   = udf_q | (|(fifo.i_rd_en & ~rd_ed));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  mton_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .NW    (M_WRITERS),
    .NR    (N_READERS)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (wr_ed),
    .i_wr_addr (wr_addr),
    .i_wr_data (fifo.i_wr_data),
    .i_rd_addr (rd_addr),
    .o_rd_data (mem_rd)
  );

  always_comb begin
    rd_data = '0;
    for (int j = 0; j < N_READERS; j++) begin
      if (rd_ed[j]) rd_data[j*WIDTH +: WIDTH] = mem_rd[j*WIDTH +: WIDTH];
    end
  end

  assign fifo.o_wr_ed     = wr_ed;
  assign fifo.o_wr_full   = (count_q == CNTW'(CAP));
  assign fifo.o_wr_afull  = (free_cnt < CNTW'(M_WRITERS));
  assign fifo.o_wr_pfull  = (count_q >= CNTW'(PFULL_TH));
  assign fifo.o_wr_remain = free_cnt;
  assign fifo.o_rd_ed     = rd_ed;
  assign fifo.o_rd_data   = rd_data;
  assign fifo.o_rd_empty  = (count_q == '0);
  assign fifo.o_rd_aempty = (count_q < CNTW'(N_READERS));
  assign fifo.o_rd_pempty = (count_q <= CNTW'(PEMPTY_TH));
  assign fifo.o_rd_depth  = count_q;
  assign fifo.o_err_ovf   = ovf_q;
  assign fifo.o_err_udf   = udf_q;

endmodule

// File: tb/tb_mton_sync_fifo.sv
// Directed and model-checked bench for mton_sync_fifo: a 2x2 instance for most
// scenarios and a 3x3 instance for gapped-lane compaction.
module tb_mton_sync_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mton_sync_fifo_if #(.WIDTH(8), .DEPTH(4), .M_WRITERS(2), .N_READERS(2)) bus2 ();
  mton_sync_fifo_if #(.WIDTH(8), .DEPTH(4), .M_WRITERS(3), .N_READERS(3)) bus3 ();

  mton_sync_fifo #(.WIDTH(8), .DEPTH(4), .M_WRITERS(2), .N_READERS(2),
                   .PFULL_TH(12), .PEMPTY_TH(4)) dut2 (
    .i_clk (clk),
    .i_rst (rst),
    .fifo  (bus2.slave)
  );

  mton_sync_fifo #(.WIDTH(8), .DEPTH(4), .M_WRITERS(3), .N_READERS(3),
                   .PFULL_TH(12), .PEMPTY_TH(4)) dut3 (
    .i_clk (clk),
    .i_rst (rst),
    .fifo  (bus3.slave)
  );

  // {full, afull, pfull, empty, aempty, pempty, ovf, udf}
  function automatic logic [7:0] status2();
    return {bus2.o_wr_full, bus2.o_wr_afull, bus2.o_wr_pfull, bus2.o_rd_empty,
            bus2.o_rd_aempty, bus2.o_rd_pempty, bus2.o_err_ovf, bus2.o_err_udf};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus2.i_wr_en = '0; bus2.i_wr_data = '0; bus2.i_rd_en = '0;
    bus3.i_wr_en = '0; bus3.i_wr_data = '0; bus3.i_rd_en = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle();
    step();
    step();
    n_checks++;
    if (status2() !== 8'b0001_1100) begin
      n_errors++; $display("FAIL reset_flags: got %b want 00011100", status2());
    end
    n_checks++;
    if ({bus2.o_wr_remain, bus2.o_rd_depth} !== {5'd16, 5'd0}) begin
      n_errors++; $display("FAIL reset_counts: got remain %0d depth %0d want 16 0",
                           bus2.o_wr_remain, bus2.o_rd_depth);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    bus2.i_wr_en = 2'b11; bus2.i_wr_data = {8'h21, 8'h12};
    step();
    bus2.i_rd_en = 2'b11;
    #1;
    n_checks++;
    if (bus2.o_rd_ed !== 2'b11 || bus2.o_rd_data !== {8'h21, 8'h12}) begin
      n_errors++; $display("FAIL pre_reset_pop: got ed %b data %h want 11 2112",
                           bus2.o_rd_ed, bus2.o_rd_data);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (status2() !== 8'b0001_1100) begin
      n_errors++; $display("FAIL async_rst_flags: got %b want 00011100", status2());
    end
    n_checks++;
    if ({bus2.o_wr_remain, bus2.o_rd_depth} !== {5'd16, 5'd0}) begin
      n_errors++; $display("FAIL async_rst_counts: got remain %0d depth %0d want 16 0",
                           bus2.o_wr_remain, bus2.o_rd_depth);
    end
    n_checks++;
    if ({bus2.o_wr_ed, bus2.o_rd_ed, bus2.o_rd_data} !== 20'h0) begin
      n_errors++; $display("FAIL async_rst_ed_data: got wed %b red %b data %h want 0 0 0",
                           bus2.o_wr_ed, bus2.o_rd_ed, bus2.o_rd_data);
    end
    idle();
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_dual_push_pop();
    bus2.i_wr_en = 2'b11; bus2.i_wr_data = {8'hBB, 8'hAA};
    #1;
    n_checks++;
    if (bus2.o_wr_ed !== 2'b11) begin
      n_errors++; $display("FAIL dual_wr_ed: got %b want 11", bus2.o_wr_ed);
    end
    step();
    idle();
    n_checks++;
    if (bus2.o_rd_depth !== 5'd2 || status2() !== 8'b0000_0100) begin
      n_errors++; $display("FAIL dual_after_push: got depth %0d flags %b want 2 00000100",
                           bus2.o_rd_depth, status2());
    end
    bus2.i_rd_en = 2'b11;
    #1;
    n_checks++;
    if (bus2.o_rd_ed !== 2'b11 || bus2.o_rd_data !== {8'hBB, 8'hAA}) begin
      n_errors++; $display("FAIL dual_pop: got ed %b data %h want 11 bbaa",
                           bus2.o_rd_ed, bus2.o_rd_data);
    end
    step();
    idle();
    n_checks++;
    if (bus2.o_rd_depth !== 5'd0) begin
      n_errors++; $display("FAIL dual_drained: got depth %0d want 0", bus2.o_rd_depth);
    end
  endtask

  task automatic test_full_boundary();
    for (int k = 0; k < 7; k++) begin
      bus2.i_wr_en = 2'b11;
      bus2.i_wr_data = {8'(2*k+1), 8'(2*k)};
      step();
    end
    bus2.i_wr_en = 2'b01; bus2.i_wr_data = {8'h99, 8'h0E};
    step();
    idle();
    n_checks++;
    if (bus2.o_rd_depth !== 5'd15 || bus2.o_wr_remain !== 5'd1 || status2() !== 8'b0110_0000) begin
      n_errors++; $display("FAIL fill15: got depth %0d remain %0d flags %b want 15 1 01100000",
                           bus2.o_rd_depth, bus2.o_wr_remain, status2());
    end
    bus2.i_wr_en = 2'b11; bus2.i_wr_data = {8'hEE, 8'h0F};
    #1;
    n_checks++;
    if (bus2.o_wr_ed !== 2'b01) begin
      n_errors++; $display("FAIL full_partial_wr: got %b want 01", bus2.o_wr_ed);
    end
    step();
    idle();
    n_checks++;
    if (status2() !== 8'b1110_0010 || bus2.o_wr_remain !== 5'd0 || bus2.o_rd_depth !== 5'd16) begin
      n_errors++; $display("FAIL full_flags: got %b remain %0d depth %0d want 11100010 0 16",
                           status2(), bus2.o_wr_remain, bus2.o_rd_depth);
    end
    bus2.i_rd_en = 2'b01;
    #1;
    n_checks++;
    if (bus2.o_rd_ed !== 2'b01 || bus2.o_rd_data !== 16'h0000) begin
      n_errors++; $display("FAIL full_pop: got ed %b data %h want 01 0000",
                           bus2.o_rd_ed, bus2.o_rd_data);
    end
    step();
    bus2.i_wr_en = 2'b11; bus2.i_wr_data = {8'h11, 8'h10}; bus2.i_rd_en = 2'b01;
    #1;
    n_checks++;
    if (bus2.o_wr_ed !== 2'b01 || bus2.o_rd_ed !== 2'b01 || bus2.o_rd_data !== 16'h0001) begin
      n_errors++; $display("FAIL pop_no_space: got wed %b red %b data %h want 01 01 0001",
                           bus2.o_wr_ed, bus2.o_rd_ed, bus2.o_rd_data);
    end
    step();
    idle();
    n_checks++;
    if (bus2.o_rd_depth !== 5'd15 || bus2.o_err_ovf !== 1'b1) begin
      n_errors++; $display("FAIL depth15_sticky: got depth %0d ovf %b want 15 1",
                           bus2.o_rd_depth, bus2.o_err_ovf);
    end
  endtask

  task automatic test_underflow();
    // Remaining contents are 0x02..0x10; draining walks across the address wrap.
    for (int k = 0; k < 7; k++) begin
      bus2.i_rd_en = 2'b11;
      #1;
      n_checks++;
      if (bus2.o_rd_data !== {8'(2*k+3), 8'(2*k+2)} || bus2.o_rd_ed !== 2'b11) begin
        n_errors++; $display("FAIL drain_%0d: got ed %b data %h want 11 %h",
                             k, bus2.o_rd_ed, bus2.o_rd_data, {8'(2*k+3), 8'(2*k+2)});
      end
      step();
    end
    bus2.i_rd_en = 2'b11;
    #1;
    n_checks++;
    if (bus2.o_rd_ed !== 2'b01 || bus2.o_rd_data !== 16'h0010) begin
      n_errors++; $display("FAIL udf_partial: got ed %b data %h want 01 0010",
                           bus2.o_rd_ed, bus2.o_rd_data);
    end
    step();
    idle();
    n_checks++;
    if (status2() !== 8'b0001_1111) begin
      n_errors++; $display("FAIL udf_flags: got %b want 00011111", status2());
    end
    bus2.i_wr_en = 2'b01; bus2.i_wr_data = {8'h00, 8'h77}; bus2.i_rd_en = 2'b01;
    #1;
    n_checks++;
    if (bus2.o_rd_ed !== 2'b00 || bus2.o_wr_ed !== 2'b01 || bus2.o_rd_data !== 16'h0) begin
      n_errors++; $display("FAIL wr_rd_empty: got wed %b red %b data %h want 01 00 0000",
                           bus2.o_wr_ed, bus2.o_rd_ed, bus2.o_rd_data);
    end
    step();
    idle();
    n_checks++;
    if (bus2.o_rd_depth !== 5'd1) begin
      n_errors++; $display("FAIL wr_rd_empty_depth: got %0d want 1", bus2.o_rd_depth);
    end
    bus2.i_rd_en = 2'b01;
    #1;
    n_checks++;
    if (bus2.o_rd_data !== 16'h0077) begin
      n_errors++; $display("FAIL latency1_word: got %h want 0077", bus2.o_rd_data);
    end
    step();
    idle();
  endtask

  task automatic test_gapped_lanes();
    bus3.i_wr_en = 3'b101; bus3.i_wr_data = {8'hCC, 8'h55, 8'hAA};
    #1;
    n_checks++;
    if (bus3.o_wr_ed !== 3'b101) begin
      n_errors++; $display("FAIL gap_wr_ed: got %b want 101", bus3.o_wr_ed);
    end
    step();
    idle();
    n_checks++;
    if (bus3.o_rd_depth !== 5'd2) begin
      n_errors++; $display("FAIL gap_depth: got %0d want 2", bus3.o_rd_depth);
    end
    bus3.i_rd_en = 3'b110;
    #1;
    n_checks++;
    if (bus3.o_rd_ed !== 3'b110 || bus3.o_rd_data !== {8'hCC, 8'hAA, 8'h00}) begin
      n_errors++; $display("FAIL gap_pop: got ed %b data %h want 110 ccaa00",
                           bus3.o_rd_ed, bus3.o_rd_data);
    end
    step();
    idle();
    n_checks++;
    if (bus3.o_rd_depth !== 5'd0) begin
      n_errors++; $display("FAIL gap_drained: got %0d want 0", bus3.o_rd_depth);
    end
  endtask

  task automatic test_random();
    logic [7:0]  q[$];
    logic        ovf_m, udf_m, heavy_wr;
    logic [1:0]  we, re, wed, red;
    logic [15:0] wd, rdx;
    logic [7:0]  exp_st;
    int          cnt, r;
    apply_reset();
    ovf_m = 1'b0;
    udf_m = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      cnt = q.size();
      exp_st = {cnt == 16, (16 - cnt) < 2, cnt >= 12, cnt == 0, cnt < 2, cnt <= 4, ovf_m, udf_m};
      n_checks++;
      if (status2() !== exp_st || {bus2.o_wr_remain, bus2.o_rd_depth} !== {5'(16 - cnt), 5'(cnt)}) begin
        n_errors++; $display("FAIL rnd_flags cyc %0d: got %b %0d/%0d want %b %0d/%0d", c,
                             status2(), bus2.o_wr_remain, bus2.o_rd_depth, exp_st, 16 - cnt, cnt);
      end
      heavy_wr = ((c / 150) % 2) == 0;
      for (int i = 0; i < 2; i++) begin
        we[i] = heavy_wr ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        re[i] = heavy_wr ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      end
      wd = 16'($urandom);
      bus2.i_wr_en = we; bus2.i_wr_data = wd; bus2.i_rd_en = re;
      #1;
      wed = '0; red = '0; rdx = '0;
      r = 0;
      for (int i = 0; i < 2; i++) begin
        if (we[i]) begin
          if (r < 16 - cnt) wed[i] = 1'b1;
          r++;
        end
      end
      r = 0;
      for (int j = 0; j < 2; j++) begin
        if (re[j]) begin
          if (r < cnt) begin
            red[j] = 1'b1;
            rdx[j*8 +: 8] = q[r];
          end
          r++;
        end
      end
      n_checks++;
      if ({bus2.o_wr_ed, bus2.o_rd_ed, bus2.o_rd_data} !== {wed, red, rdx}) begin
        n_errors++; $display("FAIL rnd_xfer cyc %0d: got wed %b red %b data %h want %b %b %h", c,
                             bus2.o_wr_ed, bus2.o_rd_ed, bus2.o_rd_data, wed, red, rdx);
      end
      ovf_m = ovf_m | (|(we & ~wed));
      udf_m = udf_m | (|(re & ~red));
      step();
      for (int j = 0; j < 2; j++) if (red[j]) void'(q.pop_front());
      for (int i = 0; i < 2; i++) if (wed[i]) q.push_back(wd[i*8 +: 8]);
    end
    idle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    test_reset();
    test_dual_push_pop();
    test_full_boundary();
    test_underflow();
    test_gapped_lanes();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
